// File: rtl/iomem_gpio.sv
`default_nettype none
// ============================================================================
// iomem_gpio : PicoSoC iomem GPIO with direction, set/clear and edge IRQs
// Rev 1.0
// ============================================================================
module iomem_gpio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          NUM_GPIO    = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  localparam logic [2:0] c_off_dout = 3'd0;
  localparam logic [2:0] c_off_dir  = 3'd1;
  localparam logic [2:0] c_off_din  = 3'd2;
  localparam logic [2:0] c_off_rise = 3'd3;
  localparam logic [2:0] c_off_fall = 3'd4;
  localparam logic [2:0] c_off_stat = 3'd5;
  localparam logic [2:0] c_off_set  = 3'd6;
  localparam logic [2:0] c_off_clr  = 3'd7;

  logic                ready_q;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_GPIO-1:0] out_q, out_d;
  logic [NUM_GPIO-1:0] dir_q, dir_d;
  logic [NUM_GPIO-1:0] rise_en_q, rise_en_d;
  logic [NUM_GPIO-1:0] fall_en_q, fall_en_d;
  logic [NUM_GPIO-1:0] stat_q, stat_d;
  logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_GPIO-1:0] prev_q;

  logic                w_hit;
  logic                w_wr;
  logic [2:0]          w_off;
  logic [31:0]         w_bytes;
  logic [NUM_GPIO-1:0] w_wbits;
  logic [NUM_GPIO-1:0] w_sync;
  logic [NUM_GPIO-1:0] w_set;
  logic [NUM_GPIO-1:0] w_clr;
  logic [NUM_GPIO-1:0] w_rsel;
  logic                w_unused;

  // ready_q in the hit term blocks a held request from being accepted twice
  assign w_hit   = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]) && !ready_q;
  assign w_wr    = w_hit && (iomem_wstrb != 4'b0000);
  assign w_off   = iomem_addr[4:2];
  assign w_bytes = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign w_wbits = iomem_wdata[NUM_GPIO-1:0] & w_bytes[NUM_GPIO-1:0];

  assign w_sync  = sync_q[SYNC_STAGES-1];
  assign w_set   = (w_sync & ~prev_q & rise_en_q) | (~w_sync & prev_q & fall_en_q);

  assign w_unused = ^{iomem_addr[1:0], iomem_wdata, w_bytes};

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w_clr     = '0;
    if (w_wr) begin
      case (w_off)
        c_off_dout: out_d     = (out_q & ~w_bytes[NUM_GPIO-1:0]) | w_wbits;
        c_off_dir:  dir_d     = (dir_q & ~w_bytes[NUM_GPIO-1:0]) | w_wbits;
        c_off_rise: rise_en_d = (rise_en_q & ~w_bytes[NUM_GPIO-1:0]) | w_wbits;
        c_off_fall: fall_en_d = (fall_en_q & ~w_bytes[NUM_GPIO-1:0]) | w_wbits;
        c_off_stat: w_clr     = w_wbits;
        c_off_set:  out_d     = out_q | w_wbits;
        c_off_clr:  out_d     = out_q & ~w_wbits;
        default:    ;
      endcase
    end
    // hardware set wins over a simultaneous W1C
    stat_d = (stat_q & ~w_clr) | w_set;
  end

  always_comb begin
    w_rsel = '0;
    case (w_off)
      c_off_dout: w_rsel = out_q;
      c_off_dir:  w_rsel = dir_q;
      c_off_din:  w_rsel = w_sync;
      c_off_rise: w_rsel = rise_en_q;
      c_off_fall: w_rsel = fall_en_q;
      c_off_stat: w_rsel = stat_q;
      default:    w_rsel = '0;
    endcase
    rdata_d = rdata_q;
    if (w_hit) begin
      rdata_d                 = '0;
      rdata_d[NUM_GPIO-1:0]   = w_rsel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      prev_q    <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      ready_q   <= w_hit;
      rdata_q   <= rdata_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      prev_q    <= w_sync;
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
  assign irq         = |stat_q;

endmodule
`default_nettype wire

// File: tb/tb_iomem_gpio.sv
`default_nettype none
// ============================================================================
// tb_iomem_gpio : scoreboard bench for iomem_gpio against a register model
// Rev 1.0
// ============================================================================
module tb_iomem_gpio;

  localparam logic [31:0] C_BASE = 32'h0300_0000;
  localparam logic [31:0] C_PM   = 32'h0000_00FF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  iomem_gpio #(.BASE_ADDR(C_BASE), .NUM_GPIO(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];

  // register-level model
  logic [31:0] m_out, m_dir, m_in, m_rise, m_fall, m_stat, m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = 0; m_dir = 0; m_in = 0; m_rise = 0; m_fall = 0; m_stat = 0; m_pend = 0;
  endtask

  function automatic logic [31:0] m_read(input int off);
    case (off)
      0: return m_out;
      1: return m_dir;
      2: return m_in;
      3: return m_rise;
      4: return m_fall;
      5: return m_stat;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input int off, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] bm, v;
    bm = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) bm |= (32'hFF << (8 * b));
    bm &= C_PM;
    v = wd & bm;
    case (off)
      0: m_out  = (m_out  & ~bm) | v;
      1: m_dir  = (m_dir  & ~bm) | v;
      3: m_rise = (m_rise & ~bm) | v;
      4: m_fall = (m_fall & ~bm) | v;
      5: m_stat = m_stat & ~v;
      6: m_out  = m_out | v;
      7: m_out  = m_out & ~v;
      default: ;
    endcase
  endtask

  // Issue one access from a negedge; valid is held across two edges so a
  // second acceptance would show up as a second ready pulse.
  task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
    bit hit;
    int off;
    hit = ((addr & 32'hFFFF_FFE0) == C_BASE);
    off = int'((addr >> 2) & 32'h7);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    if (hit) begin
      sb.push_back(m_read(off));
      if (strb != 4'b0000) m_write(off, strb, wd);
      m_stat |= m_pend;
      m_pend = 0;
    end
    @(posedge clk); @(negedge clk);
    chk("ready_rise", {31'b0, iomem_ready}, {31'b0, hit});
    chk("gpio_out", {24'b0, gpio_out}, m_out);
    chk("gpio_oe", {24'b0, gpio_oe}, m_dir);
    chk("irq", {31'b0, irq}, {31'b0, (m_stat != 0)});
    @(posedge clk); @(negedge clk);
    chk("ready_one_cycle", {31'b0, iomem_ready}, 32'h0);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
  endtask

  // Change pins at a negedge (before edge K); status lands after edge K+2.
  task automatic drive_pins(input logic [7:0] nv);
    logic [31:0] rise, fall, setb;
    logic        old_irq;
    old_irq = (m_stat != 0);
    rise = {24'b0, nv} & ~m_in;
    fall = ~{24'b0, nv} & m_in & C_PM;
    setb = (rise & m_rise) | (fall & m_fall);
    gpio_in = nv;
    m_in = {24'b0, nv};
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("irq_early", {31'b0, irq}, {31'b0, old_irq});
    @(posedge clk); @(negedge clk);
    m_stat |= setb;
    chk("irq_latency", {31'b0, irq}, {31'b0, (m_stat != 0)});
    @(posedge clk); @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn && iomem_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 expected no access at %0t", $time);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("rdata", iomem_rdata, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    gpio_in     = 8'h00;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, iomem_ready}, 32'h0);
    chk("rst_rdata", iomem_rdata, 32'h0);
    chk("rst_out", {24'b0, gpio_out}, 32'h0);
    chk("rst_oe", {24'b0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    for (int o = 0; o < 8; o++) bus(C_BASE + 32'(o * 4), 4'b0000, 32'h0);

    bus(C_BASE + 32'h00, 4'b0001, 32'h0000_00F0);
    chk("dout_f0", {24'b0, gpio_out}, 32'hF0);
    bus(C_BASE + 32'h18, 4'b1111, 32'h0000_000F);
    chk("set_ff", {24'b0, gpio_out}, 32'hFF);
    bus(C_BASE + 32'h1C, 4'b1111, 32'h0000_0081);
    chk("clr_7e", {24'b0, gpio_out}, 32'h7E);
    bus(C_BASE + 32'h18, 4'b0010, 32'h0000_0001);
    chk("set_unstrobed", {24'b0, gpio_out}, 32'h7E);

    bus(C_BASE + 32'h0C, 4'b1111, 32'h0000_0001);
    drive_pins(8'h01);
    chk("rise_irq", {31'b0, irq}, 32'h1);
    bus(C_BASE + 32'h08, 4'b0000, 32'h0);
    drive_pins(8'h00);
    bus(C_BASE + 32'h14, 4'b0000, 32'h0);

    // W1C sampled at the same edge as a new enabled rise on pin 0
    gpio_in = 8'h01;
    m_in    = 32'h1;
    m_pend  = 32'h1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    bus(C_BASE + 32'h14, 4'b1111, 32'h0000_0001);
    chk("collide_irq", {31'b0, irq}, 32'h1);
    bus(C_BASE + 32'h14, 4'b0000, 32'h0);
    bus(C_BASE + 32'h14, 4'b1111, 32'h0000_0001);
    chk("w1c_irq", {31'b0, irq}, 32'h0);

    bus(C_BASE + 32'h04, 4'b1111, 32'hFFFF_FFFF);
    bus(C_BASE + 32'h04, 4'b0000, 32'h0);
    bus(C_BASE + 32'h20, 4'b1111, 32'h0000_0000);
    bus(C_BASE + 32'h24, 4'b1111, 32'h0000_0000);
    bus(C_BASE + 32'h04, 4'b0000, 32'h0);
    bus(C_BASE + 32'h00, 4'b0000, 32'h0);

    for (int it = 0; it < 160; it++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        drive_pins(8'($urandom));
      end else if (r == 2) begin
        bus(C_BASE + 32'h20 + 32'($urandom_range(0, 7) * 4), 4'($urandom), $urandom);
      end else begin
        logic [3:0] s;
        s = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
        bus(C_BASE + 32'($urandom_range(0, 7) * 4), s, $urandom);
      end
    end

    // reset in the cycle ready is high after a DATA_OUT write
    bus(C_BASE + 32'h04, 4'b1111, 32'h0000_003C);
    iomem_valid = 1'b1;
    iomem_addr  = C_BASE;
    iomem_wstrb = 4'b1111;
    iomem_wdata = 32'h0000_00A5;
    @(posedge clk);
    #2;
    chk("pre_rst_ready", {31'b0, iomem_ready}, 32'h1);
    chk("pre_rst_out", {24'b0, gpio_out}, 32'hA5);
    resetn = 1'b0;
    #1;
    chk("async_rst_ready", {31'b0, iomem_ready}, 32'h0);
    chk("async_rst_out", {24'b0, gpio_out}, 32'h0);
    chk("async_rst_oe", {24'b0, gpio_oe}, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    chk("async_rst_rdata", iomem_rdata, 32'h0);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    m_reset();
    m_in = {24'b0, gpio_in};
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    bus(C_BASE + 32'h00, 4'b0000, 32'h0);
    bus(C_BASE + 32'h08, 4'b0000, 32'h0);
    bus(C_BASE + 32'h14, 4'b0000, 32'h0);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
